cdb_arbiter: RTL and testbench

//  Writeback stage directly downstream of the ALU and the other functional units. Buffers each unit's

---
 rtl/cdb_arbiter_pkg.sv | 30 +++
 rtl/cdb_arbiter_fifo.sv | 60 ++++++
 rtl/cdb_arbiter.sv | 80 ++++++++
 tb/tb_cdb_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB writeback stage: functional-unit result record,
// unit indices and a small modular-add helper for the round-robin search.
package cdb_arbiter_pkg;

  localparam int NUM_FU    = 4;
  localparam int ROB_IDX_W = 6;
  localparam int PREG_W    = 7;
  localparam int XLEN      = 32;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_BR  = 2'd2,
    FU_MEM = 2'd3
  } fu_idx_t;

  typedef struct packed {
    logic                 out_valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    prd;
    logic                 rd_we;
    logic [XLEN-1:0]      result;
    logic                 exception;
  } funct_unit_out_t;

  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-unit result FIFO. Readiness comes from the registered count only, so the
// grant never feeds back combinationally into fu_ready.
module fu_result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            enq_valid,
  input  funct_unit_out_t enq_data,
  output logic            enq_ready,
  input  logic            deq,
  output funct_unit_out_t head_data,
  output logic            empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  funct_unit_out_t   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic              enq, deq_ok;

  assign enq_ready = !rst && (count < CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[head];

  // A flush drops both the offered result and the pending grant.
  assign enq    = enq_valid && enq_ready && !flush;
  assign deq_ok = deq && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)    tail <= tail + 1'b1;
      if (deq_ok) head <= head + 1'b1;
      case ({enq, deq_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= enq_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: buffers each functional unit's results and grants one per
// cycle onto the common data bus in round-robin order starting at rr_ptr.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU     = cdb_arbiter_pkg::NUM_FU,
  parameter int FIFO_DEPTH = 2,
  localparam int SRC_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  funct_unit_out_t [NUM_FU-1:0]       fu_out,
  output logic            [NUM_FU-1:0]       fu_ready,
  output funct_unit_out_t                    cdb_out,
  output logic            [SRC_W-1:0]        cdb_src
);

  logic            [NUM_FU-1:0] req;
  logic            [NUM_FU-1:0] deq;
  funct_unit_out_t [NUM_FU-1:0] head_data;
  logic            [SRC_W-1:0]  rr_ptr;
  logic            [SRC_W-1:0]  winner;
  logic                         grant_vld;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    logic empty;

    fu_result_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .enq_valid (fu_out[i].out_valid),
      .enq_data  (fu_out[i]),
      .enq_ready (fu_ready[i]),
      .deq       (deq[i]),
      .head_data (head_data[i]),
      .empty     (empty)
    );

    assign req[i] = !empty;
    assign deq[i] = grant_vld && (winner == SRC_W'(i));
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_FU.
  always_comb begin
    logic [SRC_W-1:0] cand;
    grant_vld = 1'b0;
    winner    = rr_ptr;
    cand      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand = SRC_W'(wrap_add(int'(rr_ptr), k, NUM_FU));
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    cdb_out = '0;
    if (grant_vld && !rst) begin
      cdb_out           = head_data[winner];
      cdb_out.out_valid = 1'b1;
    end
  end

  assign cdb_src = winner;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= SRC_W'(wrap_add(int'(winner), 1, NUM_FU));
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: constant-table directed rows, a saturating-load
// ordering sequence, and random traffic against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = NUM_FU;
  localparam int D = 2;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        flush = 1'b0;
  funct_unit_out_t [N-1:0]     fu_out = '0;
  logic            [N-1:0]     fu_ready;
  funct_unit_out_t             cdb_out;
  logic [$clog2(N)-1:0]        cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(N), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .fu_out   (fu_out),
    .fu_ready (fu_ready),
    .cdb_out  (cdb_out),
    .cdb_src  (cdb_src)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: one queue per unit plus the round-robin start index
  funct_unit_out_t mq [N][$];
  int              m_rr = 0;

  logic [N-1:0]    obs_ready;
  funct_unit_out_t obs_cdb;
  int              obs_src;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic funct_unit_out_t mk(input int u, input int rob, input logic [31:0] d);
    funct_unit_out_t r;
    r           = '0;
    r.out_valid = 1'b1;
    r.rob_idx   = rob[ROB_IDX_W-1:0];
    r.prd       = PREG_W'(rob + u);
    r.rd_we     = 1'b1;
    r.result    = d;
    r.exception = d[0] & d[1];
    return r;
  endfunction

  function automatic int m_winner();
    for (int k = 0; k < N; k++)
      if (mq[(m_rr + k) % N].size() != 0) return (m_rr + k) % N;
    return -1;
  endfunction

  // One clock: drive at negedge, check against the model, then advance the model at posedge.
  task automatic cyc(input logic r, input logic f, input funct_unit_out_t [N-1:0] ins);
    int              w;
    logic [N-1:0]    e_ready;
    funct_unit_out_t e_cdb;
    @(negedge clk);
    rst = r; flush = f; fu_out = ins;
    #1;
    w = m_winner();
    for (int i = 0; i < N; i++) e_ready[i] = !r && (mq[i].size() < D);
    e_cdb = (r || w < 0) ? '0 : mq[w][0];
    obs_ready = fu_ready; obs_cdb = cdb_out; obs_src = int'(cdb_src);
    chk("model_ready", 64'(fu_ready), 64'(e_ready));
    chk("model_cdb", 64'(cdb_out), 64'(e_cdb));
    if (!r && w >= 0) chk("model_src", 64'(cdb_src), 64'(w));
    @(posedge clk);
    if (r || f) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0;
    end else begin
      if (w >= 0) begin
        void'(mq[w].pop_front());
        m_rr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (ins[i].out_valid && e_ready[i]) mq[i].push_back(ins[i]);
    end
  endtask

  typedef struct {
    logic        rst, flush;
    logic [3:0]  vm;
    logic [3:0][7:0] rob;
    logic [3:0]  e_ready;
    logic        e_cv;
    int          e_src;
    int          e_rob;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic f, input logic [3:0] vm,
                               input int r0, input int r1, input int r2, input int r3,
                               input logic [3:0] er, input logic ecv, input int es, input int erob);
    vec_t v;
    v.rst = r; v.flush = f; v.vm = vm;
    v.rob[0] = 8'(r0); v.rob[1] = 8'(r1); v.rob[2] = 8'(r2); v.rob[3] = 8'(r3);
    v.e_ready = er; v.e_cv = ecv; v.e_src = es; v.e_rob = erob;
    return v;
  endfunction

  // producer state for traffic phases: a result is held until accepted
  logic            pv   [N];
  funct_unit_out_t pend [N];
  int              next_rob = 0;
  int              alu_cnt  = 0;
  int              alu_cap  = 0;
  bit              track    = 1'b0;
  bit              saw_low0 = 1'b0;
  int              alu_offered[$];
  int              alu_seen[$];

  task automatic traffic(input int cycles, input int pct, input bit ctrl);
    funct_unit_out_t [N-1:0] ins;
    logic r, f;
    for (int c = 0; c < cycles; c++) begin
      for (int u = 0; u < N; u++) begin
        if (!pv[u] && pct > 0 && $urandom_range(99) < pct && (u != 0 || alu_cnt < alu_cap)) begin
          pv[u]   = 1'b1;
          pend[u] = mk(u, next_rob, $urandom);
          if (u == 0) begin
            alu_cnt++;
            alu_offered.push_back(next_rob % 64);
          end
          next_rob++;
        end
        ins[u] = pv[u] ? pend[u] : '0;
      end
      r = ctrl && ($urandom_range(199) == 0);
      f = ctrl && ($urandom_range(39) == 0);
      cyc(r, f, ins);
      if (track) begin
        if (!obs_ready[0]) saw_low0 = 1'b1;
        if (obs_cdb.out_valid && obs_src == 0) alu_seen.push_back(int'(obs_cdb.rob_idx));
      end
      for (int u = 0; u < N; u++)
        if (r || f || (pv[u] && obs_ready[u])) pv[u] = 1'b0;
    end
  endtask

  initial begin
    vec_t tbl[$];
    funct_unit_out_t [N-1:0] ins;

    // reset, idle, single ALU result, 4-way round robin, enq+grant on one FIFO,
    // full FIFO readiness, flush with buffered results
    tbl.push_back(mkv(1,0,4'b0000, 0,0,0,0,    4'b0000,0,0,0));
    tbl.push_back(mkv(1,0,4'b0000, 0,0,0,0,    4'b0000,0,0,0));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,0,0,0));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,0,0,0));
    tbl.push_back(mkv(0,0,4'b0001, 5,0,0,0,    4'b1111,0,0,0));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,1,0,5));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,0,0,0));
    tbl.push_back(mkv(0,1,4'b0000, 0,0,0,0,    4'b1111,0,0,0));
    tbl.push_back(mkv(0,0,4'b1111, 10,11,12,13,4'b1111,0,0,0));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,1,0,10));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,1,1,11));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,1,2,12));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,1,3,13));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,0,0,0));
    tbl.push_back(mkv(0,0,4'b0100, 0,0,7,0,    4'b1111,0,0,0));
    tbl.push_back(mkv(0,0,4'b0100, 0,0,8,0,    4'b1111,1,2,7));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,1,2,8));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,0,0,0));
    tbl.push_back(mkv(0,0,4'b1010, 0,20,0,21,  4'b1111,0,0,0));
    tbl.push_back(mkv(0,0,4'b1010, 0,22,0,23,  4'b1111,1,3,21));
    tbl.push_back(mkv(0,0,4'b1000, 0,0,0,24,   4'b1101,1,1,20));
    tbl.push_back(mkv(0,1,4'b0000, 0,0,0,0,    4'b0111,1,3,23));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,0,0,0));
    tbl.push_back(mkv(0,0,4'b0000, 0,0,0,0,    4'b1111,0,0,0));

    for (int t = 0; t < tbl.size(); t++) begin
      for (int u = 0; u < N; u++)
        ins[u] = tbl[t].vm[u] ? mk(u, int'(tbl[t].rob[u]), 32'h100 * tbl[t].rob[u] + u) : '0;
      cyc(tbl[t].rst, tbl[t].flush, ins);
      chk($sformatf("row%0d_ready", t), 64'(obs_ready), 64'(tbl[t].e_ready));
      chk($sformatf("row%0d_valid", t), 64'(obs_cdb.out_valid), 64'(tbl[t].e_cv));
      if (tbl[t].e_cv) begin
        chk($sformatf("row%0d_src", t), 64'(obs_src), 64'(tbl[t].e_src));
        chk($sformatf("row%0d_rob", t), 64'(obs_cdb.rob_idx), 64'(tbl[t].e_rob));
      end
    end

    // saturating load: every unit offers every cycle, ALU limited to 6 results
    for (int u = 0; u < N; u++) pv[u] = 1'b0;
    cyc(1'b1, 1'b0, '0);
    alu_cap = 6; alu_cnt = 0; track = 1'b1; next_rob = 30;
    traffic(20, 100, 1'b0);
    traffic(40, 0, 1'b0);
    track = 1'b0;
    chk("alu_ready_dropped", 64'(saw_low0), 64'(1));
    chk("alu_count", 64'(alu_seen.size()), 64'(alu_offered.size()));
    for (int k = 0; k < alu_offered.size() && k < alu_seen.size(); k++)
      chk($sformatf("alu_order%0d", k), 64'(alu_seen[k]), 64'(alu_offered[k]));

    // random traffic with occasional flush and mid-stream reset
    alu_cap = 1 << 30;
    traffic(2000, 45, 1'b1);
    traffic(20, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
